// File: rtl/inst_fetch_if_pkg.sv
// Shared types and constants for the instruction fetch interface slice.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
// Also holds the FSM state encodings; IF_PREF is only reachable when IFETCH_PREFETCH_EN is defined.
package inst_fetch_if_pkg;

    localparam int INST_ADDR_W = 32;
    localparam int INST_W      = 32;

    typedef logic [INST_ADDR_W-1:0] inst_addr_t;
    typedef logic [INST_W-1:0]      inst_t;
    typedef logic [INST_ADDR_W-3:0] tag_t;

    localparam inst_t ZERO_WORD = '0;

    typedef enum logic [1:0] {
        IF_IDLE = 2'd0,
        IF_WAIT = 2'd1,
        IF_PREF = 2'd2
    } if_state_e;

    // Word-align an instruction address (byte offset bits forced to zero).
    function automatic inst_addr_t word_addr(input inst_addr_t a);
        return {a[INST_ADDR_W-1:2], 2'b00};
    endfunction

    // Tag used by the fetch entries: the word index of the address.
    function automatic tag_t addr_tag(input inst_addr_t a);
        return a[INST_ADDR_W-1:2];
    endfunction

endpackage

// File: rtl/inst_fetch_if_if.sv
// Bundle of the pc_reg/if_id side and instruction-memory side of the fetch unit.
// Latency: n/a (wires only).
// Backpressure: stall_req_o towards the pipeline; memory side is req/ack, one outstanding.
// Ports: ce_i, addr_i, inst_o, stall_req_o (pipeline); mem_req_o, mem_addr_o, mem_ack_i, mem_rdata_i (memory).
// slave = fetch unit, master = the environment driving it.
interface inst_fetch_if_if;
    import inst_fetch_if_pkg::*;

    logic       ce_i;
    inst_addr_t addr_i;
    inst_t      inst_o;
    logic       stall_req_o;
    logic       mem_req_o;
    inst_addr_t mem_addr_o;
    logic       mem_ack_i;
    inst_t      mem_rdata_i;

    modport slave (
        input  ce_i, addr_i, mem_ack_i, mem_rdata_i,
        output inst_o, stall_req_o, mem_req_o, mem_addr_o
    );

    modport master (
        output ce_i, addr_i, mem_ack_i, mem_rdata_i,
        input  inst_o, stall_req_o, mem_req_o, mem_addr_o
    );

endinterface

// File: rtl/inst_fetch_if_fetch_entry.sv
// Single fetch entry: valid/tag/data register with combinational hit compare.
// Latency: fill visible on hit the cycle after fill_en; lookup is zero-cycle.
// Backpressure: none; fill_en is accepted every cycle.
// Ports: clk, rst (sync, active-high), fill_en/fill_tag/fill_data, lookup_tag -> hit, data.
module fetch_entry
    import inst_fetch_if_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  fill_en,
    input  tag_t  fill_tag,
    input  inst_t fill_data,
    input  tag_t  lookup_tag,
    output logic  hit,
    output inst_t data
);

    logic entry_vld;
    tag_t entry_tag;

    always_ff @(posedge clk) begin
        if (rst) begin
            entry_vld <= 1'b0;
            entry_tag <= '0;
            data      <= ZERO_WORD;
        end else if (fill_en) begin
            entry_vld <= 1'b1;
            entry_tag <= fill_tag;
            data      <= fill_data;
        end
    end

    assign hit = entry_vld && (entry_tag == lookup_tag);

endmodule

// File: rtl/inst_fetch_if.sv
// Instruction fetch front end: one-entry hold buffer in front of a req/ack instruction memory.
// Latency: hit is zero-cycle; miss returns on the cycle after mem_ack_i.
// Backpressure: stall_req_o high whenever inst_o is not valid for addr_i; one memory request outstanding.
// Ports: clk, rst (sync, active-high), bus (inst_fetch_if_if.slave).
// Build option IFETCH_PREFETCH_EN: adds a prefetch entry and IF_PREF state that fetches the next word
// after every demand fill.
module inst_fetch_if
    import inst_fetch_if_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    inst_fetch_if_if.slave bus
);

    if_state_e  state_q;
    if_state_e  state_d;
    inst_addr_t mem_addr_q;
    tag_t       lookup_tag;
    logic       any_hit;
    logic       miss;
    logic       demand_issue;
    inst_t      hit_data;

    logic       hold_fill;
    logic       hold_hit;
    inst_t      hold_data;

    logic       mem_req;
    logic       stall_req;
    inst_t      inst;

    assign lookup_tag = addr_tag(bus.addr_i);

    fetch_entry u_hold (
        .clk        (clk),
        .rst        (rst),
        .fill_en    (hold_fill),
        .fill_tag   (addr_tag(mem_addr_q)),
        .fill_data  (bus.mem_rdata_i),
        .lookup_tag (lookup_tag),
        .hit        (hold_hit),
        .data       (hold_data)
    );

`ifdef IFETCH_PREFETCH_EN
    logic  pref_fill;
    logic  pref_hit;
    inst_t pref_data;

    fetch_entry u_pref (
        .clk        (clk),
        .rst        (rst),
        .fill_en    (pref_fill),
        .fill_tag   (addr_tag(mem_addr_q)),
        .fill_data  (bus.mem_rdata_i),
        .lookup_tag (lookup_tag),
        .hit        (pref_hit),
        .data       (pref_data)
    );

    // Hold entry wins if both happen to match.
    assign any_hit  = hold_hit || pref_hit;
    assign hit_data = hold_hit ? hold_data : pref_data;

    // A demand miss seen while a prefetch is in flight is launched straight out of the
    // prefetch ack cycle, unless the word being returned is the one being asked for.
    assign demand_issue = miss &&
                          ((state_q == IF_IDLE) ||
                           ((state_q == IF_PREF) && bus.mem_ack_i &&
                            (lookup_tag != addr_tag(mem_addr_q))));
`else
    assign any_hit      = hold_hit;
    assign hit_data     = hold_data;
    assign demand_issue = miss && (state_q == IF_IDLE);
`endif

    assign miss = bus.ce_i && !any_hit;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IF_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; acks are only consumed in a requesting state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IF_IDLE: begin
                if (demand_issue) begin
                    state_d = IF_WAIT;
                end
            end
            IF_WAIT: begin
                if (bus.mem_ack_i) begin
`ifdef IFETCH_PREFETCH_EN
                    state_d = IF_PREF;
`else
                    state_d = IF_IDLE;
`endif
                end
            end
`ifdef IFETCH_PREFETCH_EN
            IF_PREF: begin
                if (bus.mem_ack_i) begin
                    state_d = demand_issue ? IF_WAIT : IF_IDLE;
                end
            end
`endif
            default: state_d = IF_IDLE;
        endcase
    end

    // Request address: latched on demand issue, held stable while a request is outstanding.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_addr_q <= ZERO_WORD;
        end else if (demand_issue) begin
            mem_addr_q <= word_addr(bus.addr_i);
`ifdef IFETCH_PREFETCH_EN
        end else if ((state_q == IF_WAIT) && bus.mem_ack_i) begin
            // Next sequential word; 0xFFFFFFFC wraps to 0 by natural overflow.
            mem_addr_q <= mem_addr_q + 32'd4;
`endif
        end
    end

    // Outputs
    always_comb begin
        hold_fill = (state_q == IF_WAIT) && bus.mem_ack_i;
`ifdef IFETCH_PREFETCH_EN
        pref_fill = (state_q == IF_PREF) && bus.mem_ack_i;
`endif
        mem_req   = (state_q != IF_IDLE);
        stall_req = !rst && miss;
        inst      = (!rst && bus.ce_i && any_hit) ? hit_data : ZERO_WORD;
    end

    assign bus.mem_req_o   = mem_req;
    assign bus.mem_addr_o  = mem_addr_q;
    assign bus.stall_req_o = stall_req;
    assign bus.inst_o      = inst;

endmodule

// File: doc/inst_fetch_if.md
INST_FETCH_IF -- requirements
Module: inst_fetch_if

Interface
REQ-001 rst  input  1  synchronous active-high reset, sampled on rising clk.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 ce_i  input  1  fetch enable from pc_reg.
REQ-004 addr_i  input  32  instruction address from pc_reg; bits [1:0] ignored.
REQ-005 inst_o  output  32  instruction word to if_id.
REQ-006 stall_req_o  output  1  high when inst_o is not valid for addr_i this cycle.
REQ-007 mem_req_o  output  1  read request to instruction memory.
REQ-008 mem_addr_o  output  32  word-aligned request address, bits [1:0] = 0.
REQ-009 mem_ack_i  input  1  memory returns mem_rdata_i this cycle.
REQ-010 mem_rdata_i  input  32  read data, valid only when mem_ack_i=1.

Function
REQ-011 Hold entry: valid bit, tag [31:2], data [31:0]; hit = valid and tag == addr_i[31:2].
REQ-012 ce_i=0: inst_o=ZeroWord, stall_req_o=0, no new request issued.
REQ-013 ce_i=1 and hit: inst_o = entry data combinationally, stall_req_o=0, zero-cycle latency.
REQ-014 ce_i=1 and miss: stall_req_o=1 and inst_o=ZeroWord in the same cycle.
REQ-015 FSM states IDLE, WAIT; IDLE->WAIT on miss with ce_i=1, latching {addr_i[31:2],2'b00} into mem_addr_o.
REQ-016 In WAIT: mem_req_o=1, mem_addr_o stable until mem_ack_i sampled high.
REQ-017 WAIT->IDLE on mem_ack_i=1; entry gets valid=1, tag=mem_addr_o[31:2], data=mem_rdata_i; hit on the next cycle if addr_i unchanged (miss-to-hit latency = ack cycle + 1).
REQ-018 addr_i change during WAIT: outstanding request completes and fills; the new address is then re-evaluated from IDLE; requests are never aborted.
REQ-019 mem_ack_i while mem_req_o=0 is ignored; state and entries do not change.
REQ-020 At most one request is outstanding at any time.

Reset
REQ-021 On rst=1: FSM=IDLE, all valid bits=0, mem_req_o=0, mem_addr_o=ZeroWord, inst_o=ZeroWord, stall_req_o=0.
REQ-022 rst during WAIT abandons the request; an ack arriving after reset is ignored per REQ-019.

Configuration
REQ-023 Macro IFETCH_PREFETCH_EN adds a second entry (prefetch buffer) and FSM state PREF.
REQ-024 With IFETCH_PREFETCH_EN: after a demand fill in WAIT, FSM->PREF and requests mem_addr_o+4, wrapping 0xFFFFFFFC -> 0x00000000.
REQ-025 With IFETCH_PREFETCH_EN: a hit in either entry satisfies REQ-013, hold entry has priority; a PREF ack fills the prefetch entry, then FSM->IDLE.
REQ-026 With IFETCH_PREFETCH_EN: a demand miss during PREF stalls until the PREF ack, then issues the demand request on the following cycle.
REQ-027 Without IFETCH_PREFETCH_EN: PREF and the second entry are absent; behaviour is exactly REQ-011..REQ-022.

Structure
REQ-028 InstAddrBus, InstBus, ZeroWord, and FSM state encodings (IfIdle, IfWait, IfPref) live in the shared defines.v.
REQ-029 One sub-module, fetch_entry (valid/tag/data register with hit compare), is instantiated once, or twice under IFETCH_PREFETCH_EN.

Verification
REQ-030 Reset then ce_i=1, addr_i=0x0; ack after 3 cycles with 0x34011100 -> stall high 4 cycles, then inst_o=0x34011100, stall low.
REQ-031 Repeat addr_i=0x0 after fill -> stall_req_o=0, mem_req_o stays 0.
REQ-032 addr_i changes 0x0->0x8 during WAIT -> mem_addr_o stays 0x0 until ack, then a new request for 0x8.
REQ-033 rst asserted in WAIT, then a stray mem_ack_i -> mem_req_o=0, no hit on 0x0 afterwards.
REQ-034 IFETCH_PREFETCH_EN, fetch 0xFFFFFFFC -> PREF request to 0x00000000; next fetch of 0x0 hits with no stall.
REQ-035 ce_i=0 with mem_ack_i pulses -> inst_o=ZeroWord, stall_req_o=0, state unchanged.
